softmax_config_master: RTL and testbench
========================================

SOFTMAX_CONFIG_MASTER -- requirements
Module: softmax_config_master

Interface
REQ-001 SHALL have parameter AW, default 12, internal memory address width (width of iolen).
REQ-002 SHALL have parameter DW, default 32, configuration data width.
REQ-003 SHALL have parameter CW, default 6, configuration address width.
REQ-004 SHALL have parameter POLL_GAP, default 16, idle cycles between successive status polls (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 32'd1_000_000, maximum poll cycles before abort.
REQ-006 SHALL have ports, with one clock; reset is asynchronous and active-low:
  clk  input  1  clock
  rst_n  input  1  asynchronous active-low reset
  start  input  1  1-cycle request to run one softmax job
  raddr  input  DW  job read address, sampled on accepted start
  waddr  input  DW  job write address, sampled on accepted start
  iolen  input  AW  job length, sampled on accepted start
  busy  output  1  job in progress
  done  output  1  1-cycle pulse at job end
  err  output  1  sticky job error, valid with done, cleared on next accepted start
  time_cost  output  32  CSR_TIME value read at job end
  config_ena  output  1  register write strobe to softmax_config
  config_addr  output  CW  register address
  config_wdata  output  DW  register write data
  config_rdata  input  DW  registered read data, valid one cycle after config_addr

Function
REQ-007 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-008 SHALL sequence FSM states IDLE -> CHK_A -> CHK_R -> W_RADDR -> W_WADDR -> W_IOLEN -> W_END0 -> W_END1 -> W_END2 -> POLL_A -> POLL_R -> GAP -> (POLL_A | TIME_A) -> TIME_R -> FIN -> IDLE, one cycle per state except GAP.
REQ-009 CHK_A SHALL drive config_addr=6'h3F, config_ena=0; CHK_R SHALL compare config_rdata to 32'hF0F0F0F0; mismatch SHALL set err and jump to FIN without any write.
REQ-010 W_RADDR/W_WADDR/W_IOLEN SHALL write addresses 0x00/0x01/0x02 with captured raddr/waddr/{zero-extended iolen}, config_ena=1 for exactly one cycle each.
REQ-011 W_END0 SHALL write 0x20 with data 0; W_END1 SHALL write 0x20 with data 1; W_END2 SHALL write 0x20 with data 0, guaranteeing a fresh rising edge of the end-of-config flag and leaving it low for the next job.
REQ-012 POLL_A SHALL drive config_addr=0x21, config_ena=0; POLL_R SHALL sample config_rdata: bit0=1 and bit1=0 -> TIME_A, else GAP.
REQ-013 GAP SHALL hold config_ena=0 for POLL_GAP cycles via a down-counter, then return to POLL_A.
REQ-014 TIME_A SHALL drive config_addr=0x22; TIME_R SHALL latch config_rdata[31:0] into time_cost.
REQ-015 FIN SHALL pulse done for one cycle, deassert busy on the same edge it enters IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE; config_ena SHALL be 1 only in W_* states.
REQ-017 config_addr/config_wdata SHALL be registered outputs; config_wdata SHALL be 0 whenever config_ena=0.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, err=0, time_cost=0, config_ena=0, config_addr=0, config_wdata=0, counters=0, including mid-job (no completion write issued).

Configuration
REQ-019 With macro SOFTMAX_CFG_TIMEOUT_EN defined, a 32-bit counter SHALL count every cycle in POLL_A/POLL_R/GAP; reaching TIMEOUT SHALL set err, skip CSR_TIME read (time_cost=32'hFFFFFFFF) and go to FIN.
REQ-020 Without SOFTMAX_CFG_TIMEOUT_EN, no timeout counter SHALL exist and polling SHALL continue indefinitely; TIMEOUT parameter unused.

Structure
REQ-021 Shared package softmax_cfg_pkg SHALL hold register address constants (0x00,0x01,0x02,0x20,0x21,0x22,0x3F), CHECK_WORD 32'hF0F0F0F0, and the FSM state enum.
REQ-022 Single flat module; no sub-module. Bench SHALL pair it with softmax_config plus a core-done stub.

Verification
REQ-023 start with raddr=0x100, waddr=0x200, iolen=10, core_done 50 cycles after config_done -> writes 0x100/0x200/10 then 0x20 data 0,1,0; done pulses once, err=0, time_cost>=50.
REQ-024 Responder returns 0x12345678 on 0x3F -> no config_ena ever asserted, done with err=1.
REQ-025 start asserted again during POLL -> ignored, captured raddr unchanged, single done.
REQ-026 rst_n low during GAP -> all outputs 0 next cycle; new start afterwards completes normally.
REQ-027 SOFTMAX_CFG_TIMEOUT_EN, TIMEOUT=100, core_done never -> done with err=1, time_cost=32'hFFFFFFFF.
REQ-028 Two back-to-back jobs -> second config_done pulse generated, second time_cost restarted from 0.

Source files
------------

// File: rtl/softmax_cfg_pkg.sv
// Shared constants and FSM state type for the softmax configuration master.
package softmax_cfg_pkg;

    localparam logic [5:0] ADDR_RADDR  = 6'h00;
    localparam logic [5:0] ADDR_WADDR  = 6'h01;
    localparam logic [5:0] ADDR_IOLEN  = 6'h02;
    localparam logic [5:0] ADDR_END    = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h21;
    localparam logic [5:0] ADDR_TIME   = 6'h22;
    localparam logic [5:0] ADDR_CHECK  = 6'h3F;

    localparam logic [31:0] CHECK_WORD = 32'hF0F0F0F0;

    typedef enum logic [3:0] {
        IDLE,
        CHK_A,
        CHK_R,
        W_RADDR,
        W_WADDR,
        W_IOLEN,
        W_END0,
        W_END1,
        W_END2,
        POLL_A,
        POLL_R,
        GAP,
        TIME_A,
        TIME_R,
        FIN
    } state_t;

    // Status word: bit0 = core finished, bit1 = core still running.
    function automatic logic core_finished(input logic [1:0] status);
        return status[0] && !status[1];
    endfunction

endpackage

// File: rtl/softmax_config_master.sv
// Drives one softmax job through softmax_config: id check, parameter writes, end-flag pulse, status poll, time read.
// Optional poll timeout enabled by defining SOFTMAX_CFG_TIMEOUT_EN.
module softmax_config_master
    import softmax_cfg_pkg::*;
#(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned CW       = 6,
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned TIMEOUT  = 32'd1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] raddr,
    input  logic [DW-1:0] waddr,
    input  logic [AW-1:0] iolen,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   time_cost,
    output logic          config_ena,
    output logic [CW-1:0] config_addr,
    output logic [DW-1:0] config_wdata,
    input  logic [DW-1:0] config_rdata
);

    state_t        state;
    state_t        state_next;

    logic [DW-1:0] raddr_q;
    logic [DW-1:0] waddr_q;
    logic [AW-1:0] iolen_q;
    logic [31:0]   gap_cnt;

    logic          ena_next;
    logic [CW-1:0] addr_next;
    logic [DW-1:0] wdata_next;

    logic          accept;
    logic          in_poll;
    logic          check_ok;
    logic          status_ok;
    logic          gap_last;
    logic          poll_abort;

    assign accept    = (state == IDLE) && start;
    assign in_poll   = (state == POLL_A) || (state == POLL_R) || (state == GAP);
    assign check_ok  = (config_rdata == DW'(CHECK_WORD));
    assign status_ok = core_finished(config_rdata[1:0]);
    assign gap_last  = (gap_cnt == '0);

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Degenerate parameter values leave an elaboration marker.
    if (POLL_GAP == 0 || TIMEOUT == 0) begin : g_bad_params
    end

`ifdef SOFTMAX_CFG_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        timeout_hit;

    assign timeout_hit = in_poll && (to_cnt == TIMEOUT - 32'd1);
    // A completed poll on the final budgeted cycle still wins over the abort.
    assign poll_abort  = timeout_hit && !((state == POLL_R) && status_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (in_poll) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end
`else
    assign poll_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHK_A;
            CHK_A:   state_next = CHK_R;
            CHK_R:   state_next = check_ok ? W_RADDR : FIN;
            W_RADDR: state_next = W_WADDR;
            W_WADDR: state_next = W_IOLEN;
            W_IOLEN: state_next = W_END0;
            W_END0:  state_next = W_END1;
            W_END1:  state_next = W_END2;
            W_END2:  state_next = POLL_A;
            POLL_A:  state_next = POLL_R;
            POLL_R:  state_next = status_ok ? TIME_A : GAP;
            GAP:     state_next = gap_last ? POLL_A : GAP;
            TIME_A:  state_next = TIME_R;
            TIME_R:  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (poll_abort) state_next = FIN;
    end

    // Bus outputs are decoded from the upcoming state and registered, so they line up with it.
    always_comb begin
        ena_next   = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        case (state_next)
            CHK_A, CHK_R: begin
                addr_next = CW'(ADDR_CHECK);
            end
            W_RADDR: begin
                ena_next   = 1'b1;
                addr_next  = CW'(ADDR_RADDR);
                wdata_next = raddr_q;
            end
            W_WADDR: begin
                ena_next   = 1'b1;
                addr_next  = CW'(ADDR_WADDR);
                wdata_next = waddr_q;
            end
            W_IOLEN: begin
                ena_next   = 1'b1;
                addr_next  = CW'(ADDR_IOLEN);
                wdata_next = DW'(iolen_q);
            end
            W_END0, W_END2: begin
                ena_next   = 1'b1;
                addr_next  = CW'(ADDR_END);
            end
            W_END1: begin
                ena_next   = 1'b1;
                addr_next  = CW'(ADDR_END);
                wdata_next = DW'(1);
            end
            POLL_A, POLL_R, GAP: begin
                addr_next = CW'(ADDR_STATUS);
            end
            TIME_A, TIME_R: begin
                addr_next = CW'(ADDR_TIME);
            end
            default: begin
                addr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_ena   <= 1'b0;
            config_addr  <= '0;
            config_wdata <= '0;
        end else begin
            config_ena   <= ena_next;
            config_addr  <= addr_next;
            config_wdata <= wdata_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q   <= '0;
            waddr_q   <= '0;
            iolen_q   <= '0;
            err       <= 1'b0;
            time_cost <= '0;
            gap_cnt   <= '0;
        end else begin
            if (accept) begin
                raddr_q <= raddr;
                waddr_q <= waddr;
                iolen_q <= iolen;
                err     <= 1'b0;
            end
            if ((state == CHK_R) && !check_ok) begin
                err <= 1'b1;
            end
            if (state == TIME_R) begin
                time_cost <= config_rdata[31:0];
            end
            if (poll_abort) begin
                err       <= 1'b1;
                time_cost <= '1;
            end
            if (state == POLL_R) begin
                gap_cnt <= POLL_GAP - 32'd1;
            end else if ((state == GAP) && !gap_last) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_softmax_config_master.sv
// Bench for softmax_config_master: behavioural softmax_config responder with core-done stub and a job-level model.
// Timeout scenario runs only when SOFTMAX_CFG_TIMEOUT_EN is defined.
module tb_softmax_config_master;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned GAP_CYC = 16;
    localparam int unsigned TO_CYC  = 100;
    localparam int BOUND = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] raddr = '0;
    logic [31:0] waddr = '0;
    logic [11:0] iolen = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] time_cost;
    logic        config_ena;
    logic [5:0]  config_addr;
    logic [31:0] config_wdata;
    logic [31:0] config_rdata;

    always #5 clk = ~clk;

    softmax_config_master #(
        .AW(AW), .DW(DW), .CW(CW), .POLL_GAP(GAP_CYC), .TIMEOUT(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .raddr(raddr), .waddr(waddr),
        .iolen(iolen), .busy(busy), .done(done), .err(err), .time_cost(time_cost),
        .config_ena(config_ena), .config_addr(config_addr),
        .config_wdata(config_wdata), .config_rdata(config_rdata)
    );

    // softmax_config stand-in: registered reads, end flag rising edge launches the core stub
    logic [31:0] chk_word = 32'hF0F0F0F0;
    int unsigned core_lat = 50;
    logic [31:0] r_regs [0:2];
    logic        end_flag;
    logic        core_run;
    logic        core_fin;
    logic [31:0] core_time;
    int          cfg_done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_rdata <= '0;
            r_regs[0] <= '0; r_regs[1] <= '0; r_regs[2] <= '0;
            end_flag <= 1'b0; core_run <= 1'b0; core_fin <= 1'b0; core_time <= '0;
        end else begin
            case (config_addr)
                6'h00, 6'h01, 6'h02: config_rdata <= r_regs[config_addr[1:0]];
                6'h20:   config_rdata <= {31'b0, end_flag};
                6'h21:   config_rdata <= {30'b0, core_run, core_fin};
                6'h22:   config_rdata <= core_time;
                6'h3F:   config_rdata <= chk_word;
                default: config_rdata <= '0;
            endcase
            if (core_run) begin
                core_time <= core_time + 32'd1;
                if (core_lat != 0 && core_time + 32'd1 == core_lat) begin
                    core_run <= 1'b0;
                    core_fin <= 1'b1;
                end
            end
            if (config_ena) begin
                if (config_addr < 6'h03) r_regs[config_addr[1:0]] <= config_wdata;
                if (config_addr == 6'h20) begin
                    end_flag <= config_wdata[0];
                    if (config_wdata[0] && !end_flag) begin
                        core_run <= 1'b1;
                        core_fin <= 1'b0;
                        core_time <= '0;
                        cfg_done_cnt <= cfg_done_cnt + 1;
                    end
                end
            end
        end
    end

    typedef struct packed { logic [5:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_q [$];
    bit          m_busy = 0;
    bit          m_fin_seen = 0;
    bit          m_fresh = 0;
    int          m_dones = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_time = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_time_cost"}, time_cost, 0);
        chk({tag, "_config_ena"}, config_ena, 0);
        chk({tag, "_config_addr"}, config_addr, 0);
        chk({tag, "_config_wdata"}, config_wdata, 0);
    endtask

    task automatic accept_job();
        m_busy = 1; m_dones = 0; m_fresh = 1;
        exp_q.delete();
        if (chk_word != 32'hF0F0F0F0) begin
            m_err = 1'b1;
        end else begin
            exp_q.push_back({6'h00, raddr});
            exp_q.push_back({6'h01, waddr});
            exp_q.push_back({6'h02, 20'b0, iolen});
            exp_q.push_back({6'h20, 32'd0});
            exp_q.push_back({6'h20, 32'd1});
            exp_q.push_back({6'h20, 32'd0});
            if (core_lat == 0) begin
                m_err = 1'b1; m_time = 32'hFFFFFFFF;
            end else begin
                m_err = 1'b0; m_time = 32'(core_lat);
            end
        end
    endtask

    task automatic compare();
        wr_t w;
        if (!rst_n) begin
            check_zero("reset");
            m_busy = 0; m_fin_seen = 0; m_err = 1'b0; m_time = '0; exp_q.delete();
            return;
        end
        chk("busy", busy, m_busy);
        if (m_fresh) begin
            chk("err_cleared_on_start", err, 0);
            m_fresh = 0;
        end
        if (config_ena) begin
            chk("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("write_addr", config_addr, w.a);
                chk("write_data", config_wdata, w.d);
            end
        end else begin
            chk("wdata_zero_when_idle", config_wdata, 0);
        end
        if (done) begin
            chk("done_inside_job", m_busy, 1);
            chk("single_done", m_dones, 0);
            m_dones++;
            chk("err_at_done", err, m_err);
            chk("time_at_done", time_cost, m_time);
            chk("writes_outstanding", exp_q.size(), 0);
            m_fin_seen = 1;
        end
        if (!m_busy) begin
            chk("err_sticky_idle", err, m_err);
            chk("time_cost_idle", time_cost, m_time);
        end
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = rst_n && start && !m_busy;
        if (m_fin_seen) begin
            m_busy = 0; m_fin_seen = 0;
        end
        if (acc) accept_job();
        @(negedge clk);
        compare();
    endtask

    // Launch a job and wait for done; p1/p2 re-assert start at those tick counts while busy.
    task automatic run_job(input logic [31:0] ra, input logic [31:0] wa, input logic [11:0] il,
                           input int p1, input int p2, output int ticks);
        raddr = ra; waddr = wa; iolen = il; start = 1'b1;
        tick();
        ticks = 1;
        start = 1'b0; raddr = ~ra; waddr = ~wa; iolen = ~il;
        while (!m_fin_seen && ticks < BOUND) begin
            start = (ticks == p1) || (ticks == p2);
            if (start) raddr = 32'hDEAD_0000;
            tick();
            ticks++;
            start = 1'b0;
        end
        chk("job_reached_done", m_fin_seen, 1);
        tick();
    endtask

    initial begin
        int t;
        int c0;

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // nominal job
        core_lat = 50; c0 = cfg_done_cnt;
        run_job(32'h100, 32'h200, 12'd10, 0, 0, t);
        chk("job1_latency", t, 67);
        chk("job1_err", err, 0);
        chk("job1_time_cost", time_cost, 32'd50);
        chk("job1_reg_raddr", r_regs[0], 32'h100);
        chk("job1_reg_waddr", r_regs[1], 32'h200);
        chk("job1_reg_iolen", r_regs[2], 32'd10);
        chk("job1_end_flag_low", end_flag, 0);
        chk("job1_config_done", cfg_done_cnt - c0, 1);

        // wrong id word: no writes, error reported
        chk_word = 32'h12345678; c0 = cfg_done_cnt;
        run_job(32'h111, 32'h222, 12'd3, 0, 0, t);
        chk("badid_latency", t, 3);
        chk("badid_err", err, 1);
        chk("badid_config_done", cfg_done_cnt - c0, 0);
        chk_word = 32'hF0F0F0F0;

        // starts while busy are ignored; max iolen
        c0 = cfg_done_cnt;
        run_job(32'h300, 32'h400, 12'hFFF, 1, 20, t);
        chk("ignore_latency", t, 67);
        chk("ignore_err_cleared", err, 0);
        chk("ignore_reg_raddr", r_regs[0], 32'h300);
        chk("ignore_reg_iolen", r_regs[2], 32'h0000_0FFF);
        chk("ignore_config_done", cfg_done_cnt - c0, 1);

        // reset while waiting in GAP
        core_lat = 300;
        raddr = 32'h900; waddr = 32'hA00; iolen = 12'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        core_lat = 50; c0 = cfg_done_cnt;
        run_job(32'h910, 32'hA10, 12'd7, 0, 0, t);
        chk("post_reset_latency", t, 67);
        chk("post_reset_time_cost", time_cost, 32'd50);
        chk("post_reset_config_done", cfg_done_cnt - c0, 1);

        // back-to-back jobs, second time restarts from zero
        c0 = cfg_done_cnt;
        run_job(32'h500, 32'h600, 12'd1, 0, 0, t);
        core_lat = 30;
        run_job(32'h700, 32'h800, 12'd0, 0, 0, t);
        chk("b2b_latency", t, 49);
        chk("b2b_time_cost", time_cost, 32'd30);
        chk("b2b_reg_iolen", r_regs[2], 32'd0);
        chk("b2b_config_done", cfg_done_cnt - c0, 2);

`ifdef SOFTMAX_CFG_TIMEOUT_EN
        core_lat = 0;
        run_job(32'hB00, 32'hC00, 12'd2, 0, 0, t);
        chk("timeout_latency", t, 109);
        chk("timeout_err", err, 1);
        chk("timeout_time_cost", time_cost, 32'hFFFFFFFF);
        core_lat = 50;
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
